// File: rtl/addr_alu_datapath_if.sv
// rtl/addr_alu_datapath_if.sv - controller-facing bus of the address/ALU datapath slice
interface addr_alu_datapath_if;
  logic [7:0]  DB;
  logic [7:0]  REG;
  logic [7:0]  M;
  logic [4:0]  abl_op;
  logic        abl_ci;
  logic [3:0]  abh_op;
  logic        cond;
  logic        ld_pc;
  logic        inc_pc;
  logic        ld_ahl;
  logic [4:0]  alu_op;
  logic        alu_ci;
  logic        alu_si;
  logic [15:0] AD;
  logic [15:0] PC;
  logic        abl_co;
  logic        pcl_co;
  logic [7:0]  alu_out;
  logic        alu_co;
  logic        alu_v;
  logic        adjh;
  logic        adjl;

  modport master (
    output DB, REG, M, abl_op, abl_ci, abh_op, cond, ld_pc, inc_pc, ld_ahl,
           alu_op, alu_ci, alu_si,
    input  AD, PC, abl_co, pcl_co, alu_out, alu_co, alu_v, adjh, adjl
  );

  modport slave (
    input  DB, REG, M, abl_op, abl_ci, abh_op, cond, ld_pc, inc_pc, ld_ahl,
           alu_op, alu_ci, alu_si,
    output AD, PC, abl_co, pcl_co, alu_out, alu_co, alu_v, adjh, adjl
  );
endinterface

// File: rtl/addr_alu_datapath.sv
// rtl/addr_alu_datapath.sv - 65C02 address generation (ABL/ABH/PC) and 8-bit ALU slice
module addr_alu_datapath #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic           clk,
  input logic           RST,
  addr_alu_datapath_if.slave bus
);

  logic [7:0] abl_q, abh_q, ahl_q, pcl_q, pch_q;
  logic [7:0] adl_base, adl_add, adl, adh_base, adh;
  logic [8:0] adl_sum;
  logic [7:0] pcl_src, pcl_d, pch_d;
  logic [8:0] pcl_sum;

  always_comb begin
    adl_base = 8'h00;
    case (bus.abl_op[4:3])
      2'b00:   adl_base = abl_q;
      2'b01:   adl_base = pcl_q;
      2'b10:   adl_base = ahl_q;
      default: adl_base = 8'h00;
    endcase
    adl_add = 8'h00;
    case (bus.abl_op[2:1])
      2'b00:   adl_add = 8'h00;
      2'b01:   adl_add = bus.DB;
      2'b10:   adl_add = bus.REG;
      default: adl_add = 8'hFF;
    endcase
    // Conditional addend drops only the offset; the carry-in still applies
    if (bus.abl_op[0] && !bus.cond)
      adl_add = 8'h00;
    adl_sum = {1'b0, adl_base} + {1'b0, adl_add} + {8'd0, bus.abl_ci};
    adl     = adl_sum[7:0];
  end

  always_comb begin
    adh_base = 8'h00;
    case (bus.abh_op[3:2])
      2'b00:   adh_base = abh_q;
      2'b01:   adh_base = pch_q;
      2'b10:   adh_base = bus.DB;
      default: adh_base = 8'h00;
    endcase
    adh = adh_base;
    case (bus.abh_op[1:0])
      2'b00:   adh = adh_base;
      2'b01:   adh = adh_base + {7'd0, adl_sum[8]};
      2'b10:   adh = adh_base + 8'hFF + {7'd0, adl_sum[8]};
      default: adh = 8'h01;
    endcase
  end

  always_comb begin
    pcl_src = bus.ld_pc ? adl : pcl_q;
    pcl_sum = {1'b0, pcl_src} + {8'd0, bus.inc_pc};
    pcl_d   = pcl_sum[7:0];
    pch_d   = (bus.ld_pc ? adh : pch_q) + {7'd0, pcl_sum[8]};
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      abl_q <= 8'h00;
      abh_q <= 8'h00;
      ahl_q <= 8'h00;
      pcl_q <= RESET_PC[7:0];
      pch_q <= RESET_PC[15:8];
    end else begin
      abl_q <= adl;
      abh_q <= adh;
      pcl_q <= pcl_d;
      pch_q <= pch_d;
      if (bus.ld_ahl)
        ahl_q <= bus.DB;
    end
  end

  assign bus.AD     = {adh, adl};
  assign bus.PC     = {pch_q, pcl_q};
  assign bus.abl_co = adl_sum[8];
  assign bus.pcl_co = pcl_sum[8];

  logic [7:0] alu_b, alu_res;
  logic [8:0] alu_sum;
  logic [4:0] alu_lo;
  logic       alu_c, alu_ovf, alu_adjh, alu_adjl;

  // Only SBC/CMP sees the inverted operand; V uses the operand actually added
  always_comb begin
    alu_b    = (bus.alu_op == 5'b00100) ? ~bus.M : bus.M;
    alu_sum  = 9'd0;
    alu_lo   = 5'd0;
    alu_res  = bus.M;
    alu_c    = 1'b0;
    alu_ovf  = 1'b0;
    alu_adjh = 1'b0;
    alu_adjl = 1'b0;
    case (bus.alu_op)
      5'b00000: alu_res = bus.REG | bus.M;
      5'b00001: alu_res = bus.REG & bus.M;
      5'b00010: alu_res = bus.REG ^ bus.M;
      5'b00011, 5'b00100: begin
        alu_sum  = {1'b0, bus.REG} + {1'b0, alu_b} + {8'd0, bus.alu_ci};
        alu_lo   = {1'b0, bus.REG[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, bus.alu_ci};
        {alu_c, alu_res} = alu_sum;
        alu_ovf  = (bus.REG[7] == alu_b[7]) && (alu_sum[7] != bus.REG[7]);
        if (bus.alu_op == 5'b00011) begin
          alu_adjl = alu_lo > 5'd9;
          alu_adjh = alu_sum > 9'h099;
        end else begin
          alu_adjl = ~alu_lo[4];
          alu_adjh = ~alu_sum[8];
        end
      end
      5'b00101: {alu_c, alu_res} = {1'b0, bus.REG} + {8'd0, bus.alu_ci};
      5'b00110: {alu_c, alu_res} = {1'b0, bus.M} + {8'd0, bus.alu_ci};
      5'b00111: {alu_c, alu_res} = {1'b0, bus.REG} + 9'h0FF + {8'd0, bus.alu_ci};
      5'b01000: {alu_c, alu_res} = {bus.REG, bus.alu_si};
      5'b01001: {alu_res, alu_c} = {bus.alu_si, bus.REG};
      5'b01010: {alu_c, alu_res} = {bus.M, bus.alu_si};
      5'b01011: {alu_res, alu_c} = {bus.alu_si, bus.M};
      default: begin
        alu_res = bus.M;
        alu_c   = 1'b0;
      end
    endcase
  end

  assign bus.alu_out = alu_res;
  assign bus.alu_co  = alu_c;
  assign bus.alu_v   = alu_ovf;
  assign bus.adjh    = alu_adjh;
  assign bus.adjl    = alu_adjl;

endmodule

// File: tb/tb_addr_alu_datapath.sv
// tb/tb_addr_alu_datapath.sv - directed and random checks of addr_alu_datapath against an arithmetic model
module tb_addr_alu_datapath;
  logic clk;
  logic RST;
  int   n_asserts;
  int   n_fail;

  int m_abl, m_abh, m_ahl, m_pc;

  addr_alu_datapath_if bus ();

  addr_alu_datapath #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model_addr(output int adl, output int co, output int adh);
    int base, add, s, hb;
    case (int'(bus.abl_op[4:3]))
      0: base = m_abl;
      1: base = m_pc % 256;
      2: base = m_ahl;
      default: base = 0;
    endcase
    case (int'(bus.abl_op[2:1]))
      0: add = 0;
      1: add = int'(bus.DB);
      2: add = int'(bus.REG);
      default: add = 255;
    endcase
    if (bus.abl_op[0] && !bus.cond) add = 0;
    s   = base + add + int'(bus.abl_ci);
    adl = s % 256;
    co  = s / 256;
    case (int'(bus.abh_op[3:2]))
      0: hb = m_abh;
      1: hb = m_pc / 256;
      2: hb = int'(bus.DB);
      default: hb = 0;
    endcase
    case (int'(bus.abh_op[1:0]))
      0: adh = hb;
      1: adh = (hb + co) % 256;
      2: adh = (hb - 1 + co + 256) % 256;
      default: adh = 1;
    endcase
  endtask

  task automatic model_alu(output int out, output int co, output int v,
                           output int aj_l, output int aj_h);
    int r, m, ci, si, s, sv;
    r = int'(bus.REG); m = int'(bus.M); ci = int'(bus.alu_ci); si = int'(bus.alu_si);
    out = m; co = 0; v = 0; aj_l = 0; aj_h = 0;
    case (int'(bus.alu_op))
      0: out = r | m;
      1: out = r & m;
      2: out = r ^ m;
      3: begin
        s = r + m + ci; out = s % 256; co = s / 256;
        sv = sgn(r) + sgn(m) + ci; v = int'(sv > 127 || sv < -128);
        aj_l = int'((r % 16) + (m % 16) + ci > 9);
        aj_h = int'(s > 153);
      end
      4: begin
        s = r - m - 1 + ci + 256; out = s % 256; co = s / 256;
        sv = sgn(r) - sgn(m) - 1 + ci; v = int'(sv > 127 || sv < -128);
        aj_l = int'((r % 16) - (m % 16) - 1 + ci < 0);
        aj_h = int'(co == 0);
      end
      5: begin s = r + ci; out = s % 256; co = s / 256; end
      6: begin s = m + ci; out = s % 256; co = s / 256; end
      7: begin s = r - 1 + ci; out = (s + 256) % 256; co = int'(s >= 0); end
      8: begin out = (r * 2 + si) % 256; co = r / 128; end
      9: begin out = si * 128 + r / 2; co = r % 2; end
      10: begin out = (m * 2 + si) % 256; co = m / 128; end
      11: begin out = si * 128 + m / 2; co = m % 2; end
      default: begin out = m; co = 0; end
    endcase
  endtask

  task automatic check_all();
    int adl, aco, adh, out, co, v, aj_l, aj_h, src;
    #1;
    model_addr(adl, aco, adh);
    model_alu(out, co, v, aj_l, aj_h);
    src = bus.ld_pc ? adh * 256 + adl : m_pc;
    chk("AD", int'(bus.AD), adh * 256 + adl);
    chk("PC", int'(bus.PC), m_pc);
    chk("abl_co", int'(bus.abl_co), aco);
    chk("pcl_co", int'(bus.pcl_co), int'((src % 256) + int'(bus.inc_pc) > 255));
    chk("alu_out", int'(bus.alu_out), out);
    chk("alu_co", int'(bus.alu_co), co);
    chk("alu_v", int'(bus.alu_v), v);
    chk("adjl", int'(bus.adjl), aj_l);
    chk("adjh", int'(bus.adjh), aj_h);
  endtask

  task automatic tick();
    int adl, aco, adh, n_abl, n_abh, n_ahl, n_pc;
    model_addr(adl, aco, adh);
    n_abl = adl;
    n_abh = adh;
    n_ahl = bus.ld_ahl ? int'(bus.DB) : m_ahl;
    n_pc  = ((bus.ld_pc ? adh * 256 + adl : m_pc) + int'(bus.inc_pc)) % 65536;
    @(posedge clk);
    m_abl = n_abl; m_abh = n_abh; m_ahl = n_ahl; m_pc = n_pc;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.DB = 8'h00; bus.REG = 8'h00; bus.M = 8'h00;
    bus.abl_op = 5'b00000; bus.abl_ci = 1'b0; bus.abh_op = 4'b0000;
    bus.cond = 1'b0; bus.ld_pc = 1'b0; bus.inc_pc = 1'b0; bus.ld_ahl = 1'b0;
    bus.alu_op = 5'b00000; bus.alu_ci = 1'b0; bus.alu_si = 1'b0;
  endtask

  task automatic load_pc(input logic [7:0] hi, input logic [7:0] lo);
    idle_inputs();
    bus.REG = lo; bus.abl_op = 5'b11100;
    bus.DB = hi;  bus.abh_op = 4'b1000;
    bus.ld_pc = 1'b1;
    check_all();
    tick();
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    m_abl = 0; m_abh = 0; m_ahl = 0; m_pc = 0;
    RST = 1'b0;
    idle_inputs();
    #2;
    chk("reset_PC", int'(bus.PC), 16'h0000);
    chk("reset_AD", int'(bus.AD), 16'h0000);
    @(negedge clk);
    RST = 1'b1;

    bus.abl_op = 5'b01000; bus.abh_op = 4'b0100;
    check_all();
    chk("ad_eq_pc", int'(bus.AD), int'(bus.PC));
    tick();

    load_pc(8'h12, 8'hFF);
    idle_inputs();
    bus.abl_op = 5'b01000; bus.abh_op = 4'b0100; bus.inc_pc = 1'b1;
    check_all();
    chk("inc_AD", int'(bus.AD), 16'h12FF);
    chk("inc_pcl_co", int'(bus.pcl_co), 1);
    tick();
    idle_inputs();
    #1;
    chk("inc_PC", int'(bus.PC), 16'h1300);

    idle_inputs();
    bus.DB = 8'hF0; bus.ld_ahl = 1'b1;
    check_all();
    tick();
    idle_inputs();
    bus.abl_op = 5'b10100; bus.REG = 8'h20; bus.abh_op = 4'b1001; bus.DB = 8'h34;
    check_all();
    chk("idx_AD", int'(bus.AD), 16'h3510);
    chk("idx_co", int'(bus.abl_co), 1);
    tick();

    load_pc(8'h20, 8'h80);
    idle_inputs();
    bus.DB = 8'hFE; bus.abl_op = 5'b01011; bus.abh_op = 4'b0110; bus.cond = 1'b0;
    check_all();
    chk("br_nt_ADL", int'(bus.AD[7:0]), 8'h80);
    bus.cond = 1'b1;
    check_all();
    chk("br_t_AD", int'(bus.AD), 16'h207E);
    chk("br_t_co", int'(bus.abl_co), 1);
    tick();

    idle_inputs();
    bus.alu_op = 5'b00011; bus.REG = 8'h45; bus.M = 8'h38; bus.alu_ci = 1'b1;
    check_all();
    chk("adc_out", int'(bus.alu_out), 8'h7E);
    chk("adc_flags", int'({bus.alu_co, bus.alu_v, bus.adjl, bus.adjh}), 4'b0010);
    bus.REG = 8'h7F; bus.M = 8'h01; bus.alu_ci = 1'b0;
    check_all();
    chk("adc_v_out", int'(bus.alu_out), 8'h80);
    chk("adc_v", int'(bus.alu_v), 1);
    bus.alu_op = 5'b00100; bus.REG = 8'h10; bus.M = 8'h01; bus.alu_ci = 1'b1;
    check_all();
    chk("sbc_out", int'(bus.alu_out), 8'h0F);
    chk("sbc_flags", int'({bus.alu_co, bus.adjl, bus.adjh}), 3'b110);
    bus.alu_op = 5'b01000; bus.REG = 8'h81; bus.alu_si = 1'b1;
    check_all();
    chk("asl_out", int'(bus.alu_out), 8'h03);
    chk("asl_co", int'(bus.alu_co), 1);
    tick();

    for (int i = 0; i < 300; i++) begin
      bus.DB = 8'($urandom); bus.REG = 8'($urandom); bus.M = 8'($urandom);
      bus.abl_op = 5'($urandom); bus.abl_ci = 1'($urandom);
      bus.abh_op = 4'($urandom); bus.cond = 1'($urandom);
      bus.ld_pc = 1'($urandom); bus.inc_pc = 1'($urandom); bus.ld_ahl = 1'($urandom);
      bus.alu_op = 5'($urandom_range(0, 15)); bus.alu_ci = 1'($urandom);
      bus.alu_si = 1'($urandom);
      check_all();
      tick();
    end

    load_pc(8'hFF, 8'hFF);
    idle_inputs();
    bus.inc_pc = 1'b1;
    tick();
    idle_inputs();
    #1;
    chk("pc_wrap", int'(bus.PC), 16'h0000);

    load_pc(8'hAB, 8'hCD);
    idle_inputs();
    bus.DB = 8'h55; bus.ld_ahl = 1'b1; bus.abl_op = 5'b11010;
    tick();
    @(posedge clk);
    #2;
    RST = 1'b0;
    idle_inputs();
    #1;
    m_abl = 0; m_abh = 0; m_ahl = 0; m_pc = 0;
    chk("async_PC", int'(bus.PC), 16'h0000);
    chk("async_AD", int'(bus.AD), 16'h0000);
    @(negedge clk);
    RST = 1'b1;
    bus.abl_op = 5'b10000;
    check_all();
    chk("async_AHL", int'(bus.AD[7:0]), 8'h00);
    bus.abl_op = 5'b01000; bus.abh_op = 4'b0100;
    check_all();
    chk("post_rst_AD", int'(bus.AD), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/addr_alu_datapath.md
Name: addr_alu_datapath

Overview:
- Combined address-generation and ALU datapath slice of the 65C02 core.
- Contains three parts:
  - ABL: low address byte plus PCL and the AHL holding register.
  - ABH: high address byte plus PCH.
  - ALU: 8-bit combinational ALU with BCD adjust outputs.
- All ops are driven by the microcode controller. AD is combinational so a memory access can start in the same cycle.

Parameters:
- RESET_PC, 16'h0000, value loaded into PC on reset.

Ports:
- clk  in  1  CPU clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- DB  in  8  data bus input.
- REG  in  8  register-file output (R).
- M  in  8  registered data operand for the ALU.
- abl_op  in  5  ABL operation.
- abl_ci  in  1  ABL carry in.
- abh_op  in  4  ABH operation.
- cond  in  1  branch condition.
- ld_pc  in  1  load PC from the address.
- inc_pc  in  1  increment PC.
- ld_ahl  in  1  load AHL from DB.
- alu_op  in  5  ALU operation.
- alu_ci  in  1  ALU carry in.
- alu_si  in  1  ALU shift in.
- AD  out  16  address bus {ADH,ADL}, combinational.
- PC  out  16  program counter {PCH,PCL}, registered.
- abl_co  out  1  ADL adder carry out.
- pcl_co  out  1  PCL increment carry.
- alu_out  out  8  ALU result.
- alu_co  out  1  ALU carry out.
- alu_v  out  1  signed overflow.
- adjh  out  1  BCD high-nibble adjust.
- adjl  out  1  BCD low-nibble adjust.

Behaviour:
- Reset (RST=0, async): ABL=0, ABH=0, AHL=0, PC=RESET_PC. Outputs then follow combinationally from these values.

ABL (combinational ADL = base + addend + abl_ci, mod 256; abl_co is bit 8):
- abl_op[4:3] selects the base:
  - 00: ABL register
  - 01: PCL
  - 10: AHL
  - 11: 8'h00
- abl_op[2:1] selects the addend:
  - 00: 0
  - 01: DB
  - 10: REG
  - 11: 8'hFF
- abl_op[0]=1 makes the addend conditional: it is forced to 0 when cond=0. abl_ci is still added.

ABH (combinational ADH):
- abh_op[3:2] selects the base:
  - 00: ABH register
  - 01: PCH
  - 10: DB
  - 11: 8'h00
- abh_op[1:0] selects the modifier:
  - 00: base
  - 01: base + abl_co
  - 10: base + 8'hFF + abl_co (negative branch offset)
  - 11: constant 8'h01 (stack page), base ignored
- Any overflow past 8 bits is discarded.

Registers (every rising clk):
- ABL <= ADL and ABH <= ADH, unconditionally.
- AHL <= DB when ld_ahl; otherwise AHL holds.
- PCL:
  - ld_pc=1: {pcl_co, next PCL} = ADL + inc_pc.
  - ld_pc=0: {pcl_co, next PCL} = PCL + inc_pc.
  - pcl_co is combinational.
- PCH:
  - ld_pc=1: next PCH = ADH + pcl_co.
  - ld_pc=0: next PCH = PCH + pcl_co.
- PC wraps from FFFF to 0000.

ALU (combinational; B = M, or ~M for subtract ops):
- 00000 OR: R|M, CO=0.
- 00001 AND: R&M, CO=0.
- 00010 EOR: R^M, CO=0.
- 00011 ADC: R+M+CI.
- 00100 SBC/CMP: R+~M+CI.
- 00101 pass R: R+CI.
- 00110 pass M: M+CI.
- 00111 DEC R: R+8'hFF+CI.
- 01000 ASL R: {R[6:0],SI}, CO=R[7].
- 01001 LSR R: {SI,R[7:1]}, CO=R[0].
- 01010 ASL M: {M[6:0],SI}, CO=M[7].
- 01011 LSR M: {SI,M[7:1]}, CO=M[0].
- Any other op: OUT=M, CO=0.
- V (for 00011 and 00100): (R[7]==B[7]) & (OUT[7]!=R[7]). V=0 for all other ops.
- adjl / adjh for ADC:
  - adjl = (R[3:0]+M[3:0]+CI) > 9.
  - adjh = 9-bit (R+M+CI) > 9'h099.
- adjl / adjh for SBC:
  - adjl = no carry out of bit 3.
  - adjh = ~CO.
- adjl = adjh = 0 for all other ops.

Test Plan:
- Reset: assert RST=0 mid-cycle -> PC=0000 and AD=0000 immediately; after release with abl_op=01000, abh_op=0100 -> AD=PC.
- PC increment: PC=12FF, abl_op=01000, abh_op=0100, inc_pc=1 -> AD=12FF, pcl_co=1, next PC=1300.
- Indexed with page cross: abl_op=10100 (AHL+REG), AHL=F0, REG=20, abh_op=1001, DB=34 -> ADL=10, abl_co=1, AD=3510.
- Conditional branch: PC=2080, DB=FE, abl_op=01011, cond=0 -> ADL=80; cond=1 -> ADL=7E, abl_co=1; with abh_op=0110 -> AD=207E.
- ADC with BCD and overflow: R=45, M=38, CI=1 -> OUT=7E, CO=0, V=0, adjl=1, adjh=0; R=7F, M=01, CI=0 -> OUT=80, V=1.
- SBC and shift: R=10, M=01, CI=1 op 00100 -> OUT=0F, CO=1, adjl=1, adjh=0; op 01000 with R=81, SI=1 -> OUT=03, CO=1.
